// File: rtl/sbox_pkg.sv
// ---------------------------------------------------------------------------
// sbox_pkg
// Shared definitions for the serial DES substitution unit.
//   state_t    : control states of sbox_serial_unit (IDLE, SUB, DONE)
//   SBOX_TABLE : the eight DES S-boxes S1..S8, each flattened to 64 entries.
//                Entry index is row*16 + column, where row = {b5,b0} and
//                column = b4..b1 of the 6-bit group.
// ---------------------------------------------------------------------------
package sbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SBOX_TABLE [8][64] = '{
    // S1
    '{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7,
      4'h0,4'hF,4'h7,4'h4,4'hE,4'h2,4'hD,4'h1,4'hA,4'h6,4'hC,4'hB,4'h9,4'h5,4'h3,4'h8,
      4'h4,4'h1,4'hE,4'h8,4'hD,4'h6,4'h2,4'hB,4'hF,4'hC,4'h9,4'h7,4'h3,4'hA,4'h5,4'h0,
      4'hF,4'hC,4'h8,4'h2,4'h4,4'h9,4'h1,4'h7,4'h5,4'hB,4'h3,4'hE,4'hA,4'h0,4'h6,4'hD},
    // S2
    '{4'hF,4'h1,4'h8,4'hE,4'h6,4'hB,4'h3,4'h4,4'h9,4'h7,4'h2,4'hD,4'hC,4'h0,4'h5,4'hA,
      4'h3,4'hD,4'h4,4'h7,4'hF,4'h2,4'h8,4'hE,4'hC,4'h0,4'h1,4'hA,4'h6,4'h9,4'hB,4'h5,
      4'h0,4'hE,4'h7,4'hB,4'hA,4'h4,4'hD,4'h1,4'h5,4'h8,4'hC,4'h6,4'h9,4'h3,4'h2,4'hF,
      4'hD,4'h8,4'hA,4'h1,4'h3,4'hF,4'h4,4'h2,4'hB,4'h6,4'h7,4'hC,4'h0,4'h5,4'hE,4'h9},
    // S3
    '{4'hA,4'h0,4'h9,4'hE,4'h6,4'h3,4'hF,4'h5,4'h1,4'hD,4'hC,4'h7,4'hB,4'h4,4'h2,4'h8,
      4'hD,4'h7,4'h0,4'h9,4'h3,4'h4,4'h6,4'hA,4'h2,4'h8,4'h5,4'hE,4'hC,4'hB,4'hF,4'h1,
      4'hD,4'h6,4'h4,4'h9,4'h8,4'hF,4'h3,4'h0,4'hB,4'h1,4'h2,4'hC,4'h5,4'hA,4'hE,4'h7,
      4'h1,4'hA,4'hD,4'h0,4'h6,4'h9,4'h8,4'h7,4'h4,4'hF,4'hE,4'h3,4'hB,4'h5,4'h2,4'hC},
    // S4
    '{4'h7,4'hD,4'hE,4'h3,4'h0,4'h6,4'h9,4'hA,4'h1,4'h2,4'h8,4'h5,4'hB,4'hC,4'h4,4'hF,
      4'hD,4'h8,4'hB,4'h5,4'h6,4'hF,4'h0,4'h3,4'h4,4'h7,4'h2,4'hC,4'h1,4'hA,4'hE,4'h9,
      4'hA,4'h6,4'h9,4'h0,4'hC,4'hB,4'h7,4'hD,4'hF,4'h1,4'h3,4'hE,4'h5,4'h2,4'h8,4'h4,
      4'h3,4'hF,4'h0,4'h6,4'hA,4'h1,4'hD,4'h8,4'h9,4'h4,4'h5,4'hB,4'hC,4'h7,4'h2,4'hE},
    // S5
    '{4'h2,4'hC,4'h4,4'h1,4'h7,4'hA,4'hB,4'h6,4'h8,4'h5,4'h3,4'hF,4'hD,4'h0,4'hE,4'h9,
      4'hE,4'hB,4'h2,4'hC,4'h4,4'h7,4'hD,4'h1,4'h5,4'h0,4'hF,4'hA,4'h3,4'h9,4'h8,4'h6,
      4'h4,4'h2,4'h1,4'hB,4'hA,4'hD,4'h7,4'h8,4'hF,4'h9,4'hC,4'h5,4'h6,4'h3,4'h0,4'hE,
      4'hB,4'h8,4'hC,4'h7,4'h1,4'hE,4'h2,4'hD,4'h6,4'hF,4'h0,4'h9,4'hA,4'h4,4'h5,4'h3},
    // S6
    '{4'hC,4'h1,4'hA,4'hF,4'h9,4'h2,4'h6,4'h8,4'h0,4'hD,4'h3,4'h4,4'hE,4'h7,4'h5,4'hB,
      4'hA,4'hF,4'h4,4'h2,4'h7,4'hC,4'h9,4'h5,4'h6,4'h1,4'hD,4'hE,4'h0,4'hB,4'h3,4'h8,
      4'h9,4'hE,4'hF,4'h5,4'h2,4'h8,4'hC,4'h3,4'h7,4'h0,4'h4,4'hA,4'h1,4'hD,4'hB,4'h6,
      4'h4,4'h3,4'h2,4'hC,4'h9,4'h5,4'hF,4'hA,4'hB,4'hE,4'h1,4'h7,4'h6,4'h0,4'h8,4'hD},
    // S7
    '{4'h4,4'hB,4'h2,4'hE,4'hF,4'h0,4'h8,4'hD,4'h3,4'hC,4'h9,4'h7,4'h5,4'hA,4'h6,4'h1,
      4'hD,4'h0,4'hB,4'h7,4'h4,4'h9,4'h1,4'hA,4'hE,4'h3,4'h5,4'hC,4'h2,4'hF,4'h8,4'h6,
      4'h1,4'h4,4'hB,4'hD,4'hC,4'h3,4'h7,4'hE,4'hA,4'hF,4'h6,4'h8,4'h0,4'h5,4'h9,4'h2,
      4'h6,4'hB,4'hD,4'h8,4'h1,4'h4,4'hA,4'h7,4'h9,4'h5,4'h0,4'hF,4'hE,4'h2,4'h3,4'hC},
    // S8
    '{4'hD,4'h2,4'h8,4'h4,4'h6,4'hF,4'hB,4'h1,4'hA,4'h9,4'h3,4'hE,4'h5,4'h0,4'hC,4'h7,
      4'h1,4'hF,4'hD,4'h8,4'hA,4'h3,4'h7,4'h4,4'hC,4'h5,4'h6,4'hB,4'h0,4'hE,4'h9,4'h2,
      4'h7,4'hB,4'h4,4'h1,4'h9,4'hC,4'hE,4'h2,4'h0,4'h6,4'hA,4'hD,4'hF,4'h3,4'h5,4'h8,
      4'h2,4'h1,4'hE,4'h7,4'h4,4'hA,4'h8,4'hD,4'hF,4'hC,4'h9,4'h0,4'h3,4'h5,4'h6,4'hB}
  };

endpackage

// File: rtl/sbox_lut.sv
// ---------------------------------------------------------------------------
// sbox_lut
// Purely combinational lookup of one DES S-box.
//   i_box    : which S-box (0 = S1 ... 7 = S8)
//   i_group  : 6-bit input group b5..b0
//   o_nibble : 4-bit substitution result
// ---------------------------------------------------------------------------
module sbox_lut
  import sbox_pkg::*;
(
  input  logic [2:0] i_box,
  input  logic [5:0] i_group,
  output logic [3:0] o_nibble
);

  // Outer bits select the row, inner four bits the column.
  assign o_nibble = SBOX_TABLE[i_box][{i_group[5], i_group[0], i_group[4:1]}];

endmodule

// File: rtl/sbox_serial_unit.sv
// ---------------------------------------------------------------------------
// sbox_serial_unit
// Applies the eight DES S-boxes to a 48-bit block, LANES boxes per cycle,
// so one block takes STEPS = 8/LANES substitution cycles.
//   clk, n_rst           : clock, asynchronous active-low reset
//   clear                : synchronous abort back to IDLE
//   in_valid/in_ready    : input handshake, in_48bit = eight 6-bit groups
//                          ([47:42] -> S1 ... [5:0] -> S8)
//   out_valid/out_ready  : output handshake, out_32bit = S1 nibble in
//                          [31:28] ... S8 nibble in [3:0]
//   busy                 : high while a block is in SUB or DONE
// ---------------------------------------------------------------------------
module sbox_serial_unit
  import sbox_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_48bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_32bit,
  output logic        busy
);

  localparam int STEPS = 8 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_count;
  logic [47:0]   r_block;
  logic [31:0]   r_work;
  logic [31:0]   r_out;
  logic [31:0]   w_workNext;
  logic          w_lastStep;
  logic [2:0]    w_boxes  [LANES];
  logic [5:0]    w_groups [LANES];
  logic [3:0]    w_nibs   [LANES];

  assign w_lastStep = (r_count == CW'(STEPS - 1));

  // Lane g handles box r_count*LANES + g in the current step.
  for (genvar g = 0; g < LANES; g++) begin : gLane
    assign w_boxes[g]  = 3'(int'(r_count) * LANES + g);
    assign w_groups[g] = r_block[42 - 6 * int'(w_boxes[g]) +: 6];

    sbox_lut u_lut (
      .i_box    (w_boxes[g]),
      .i_group  (w_groups[g]),
      .o_nibble (w_nibs[g])
    );
  end

  // Merge this step's nibbles into the working result.
  always_comb begin
    w_workNext = r_work;
    for (int g = 0; g < LANES; g++) begin
      w_workNext[28 - 4 * int'(w_boxes[g]) +: 4] = w_nibs[g];
    end
  end

  // Next state and handshake outputs; clear overrides every transition.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = ST_SUB;
      end
      ST_SUB: begin
        busy = 1'b1;
        if (w_lastStep) w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
    if (clear) w_stateNext = ST_IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // The published result lives in r_out and only changes when a block
  // completes, so an aborted block never disturbs out_32bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_block <= '0;
      r_work  <= '0;
      r_out   <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_block <= in_48bit;
            r_count <= '0;
          end
        end
        ST_SUB: begin
          r_work <= w_workNext;
          if (w_lastStep) begin
            r_out   <= w_workNext;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_32bit = r_out;

endmodule

// File: tb/tb_sbox_serial_unit.sv
// ---------------------------------------------------------------------------
// tb_sbox_serial_unit
// Four instances (LANES = 1, 2, 4, 8) share clock and reset; each has its
// own handshake signals. A behavioural model predicts every output cycle.
// ---------------------------------------------------------------------------
module tb_sbox_serial_unit;

  localparam int STEPS_OF [4] = '{8, 4, 2, 1};

  logic        clk;
  logic        nRst;
  logic        clearIn  [4];
  logic        inValid  [4];
  logic        inReady  [4];
  logic [47:0] in48     [4];
  logic        outValid [4];
  logic        outReady [4];
  logic [31:0] out32    [4];
  logic        busy     [4];

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  // Model state per instance: phase 0 = idle, 1 = substituting, 2 = holding result.
  int          mPhase   [4];
  int          mLeft    [4];
  logic [31:0] mPending [4];
  logic [31:0] mOut     [4];

  // Textbook DES S-boxes as [box][row][column].
  int desTab [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  // One DUT per lane count; instance i has LANES = 2**i.
  for (genvar gi = 0; gi < 4; gi++) begin : gDut
    sbox_serial_unit #(.LANES(1 << gi)) u_dut (
      .clk       (clk),
      .n_rst     (nRst),
      .clear     (clearIn[gi]),
      .in_valid  (inValid[gi]),
      .in_ready  (inReady[gi]),
      .in_48bit  (in48[gi]),
      .out_valid (outValid[gi]),
      .out_ready (outReady[gi]),
      .out_32bit (out32[gi]),
      .busy      (busy[gi])
    );
  end

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full 48-bit block to 32-bit result straight from the DES tables.
  function automatic logic [31:0] refModel(input logic [47:0] blk);
    logic [31:0] res;
    int grp, row, col;
    res = '0;
    for (int b = 0; b < 8; b++) begin
      grp = int'((blk >> (6 * (7 - b))) & 48'h3F);
      row = ((grp >> 5) & 1) * 2 + (grp & 1);
      col = (grp >> 1) & 15;
      res = (res << 4) | 32'(desTab[b][row][col]);
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Transaction-level model: an accepted block emerges STEPS edges later and
  // is held until consumed; clear and reset discard whatever is in flight.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 4; i++) begin
        mPhase[i]   <= 0;
        mLeft[i]    <= 0;
        mPending[i] <= '0;
        mOut[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clearIn[i]) begin
          mPhase[i] <= 0;
        end else if (mPhase[i] == 0) begin
          if (inValid[i]) begin
            mPhase[i]   <= 1;
            mLeft[i]    <= STEPS_OF[i];
            mPending[i] <= refModel(in48[i]);
          end
        end else if (mPhase[i] == 1) begin
          mLeft[i] <= mLeft[i] - 1;
          if (mLeft[i] == 1) begin
            mPhase[i] <= 2;
            mOut[i]   <= mPending[i];
          end
        end else if (outReady[i]) begin
          mPhase[i] <= 0;
        end
      end
    end
  end

  // Every falling edge, compare all four DUTs against the model.
  always @(negedge clk) begin
    if (nRst && checkEn) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("inReady[%0d]", i), 32'(inReady[i]), 32'(mPhase[i] == 0));
        checkOutput($sformatf("outValid[%0d]", i), 32'(outValid[i]), 32'(mPhase[i] == 2));
        checkOutput($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(mPhase[i] != 0));
        if (mPhase[i] != 1)
          checkOutput($sformatf("out32[%0d]", i), out32[i], mOut[i]);
      end
    end
  end

  // Send one block to instance i, wait (bounded) for the result, stall for
  // 'stall' cycles (optionally offering a new block meanwhile), then consume.
  task automatic applyStimulus(input int i, input logic [47:0] data, input int stall,
                               input bit poke, output int latency,
                               output logic [31:0] result);
    @(negedge clk);
    inValid[i]  = 1'b1;
    in48[i]     = data;
    outReady[i] = 1'b0;
    @(negedge clk);
    inValid[i] = 1'b0;
    latency = 0;
    while (!outValid[i] && latency < 40) begin
      @(negedge clk);
      latency++;
    end
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        inValid[i] = 1'b1;
        in48[i]    = ~data;
      end
      @(negedge clk);
    end
    inValid[i]  = 1'b0;
    result      = out32[i];
    outReady[i] = 1'b1;
    @(negedge clk);
    outReady[i] = 1'b0;
  endtask

  // Hard stop in case a handshake never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by random traffic on every lane count.
  initial begin
    int          lat;
    logic [31:0] res;
    logic [47:0] blk;

    nRst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clearIn[i]  = 1'b0;
      inValid[i]  = 1'b0;
      outReady[i] = 1'b0;
      in48[i]     = '0;
    end

    #3;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rstInReady[%0d]", i), 32'(inReady[i]), 32'd1);
      checkOutput($sformatf("rstOutValid[%0d]", i), 32'(outValid[i]), 32'd0);
      checkOutput($sformatf("rstBusy[%0d]", i), 32'(busy[i]), 32'd0);
      checkOutput($sformatf("rstOut32[%0d]", i), out32[i], 32'd0);
    end
    checkOutput("refZero", refModel(48'h0), 32'hEFA72C4D);
    checkOutput("refOnes", refModel(48'hFFFFFFFFFFFF), 32'hD9CE3DCB);

    #9 nRst = 1'b1;
    checkEn = 1'b1;

    $display("[TB] directed latency and data");
    applyStimulus(1, 48'h0, 0, 1'b0, lat, res);
    checkOutput("l2ZeroData", res, 32'hEFA72C4D);
    checkOutput("l2ZeroLat", 32'(lat), 32'd4);
    applyStimulus(0, 48'hFFFFFFFFFFFF, 0, 1'b0, lat, res);
    checkOutput("l1OnesData", res, 32'hD9CE3DCB);
    checkOutput("l1OnesLat", 32'(lat), 32'd8);
    applyStimulus(3, 48'hFFFFFFFFFFFF, 0, 1'b0, lat, res);
    checkOutput("l8OnesData", res, 32'hD9CE3DCB);
    checkOutput("l8OnesLat", 32'(lat), 32'd1);
    applyStimulus(2, 48'h0, 0, 1'b0, lat, res);
    checkOutput("l4ZeroData", res, 32'hEFA72C4D);
    checkOutput("l4ZeroLat", 32'(lat), 32'd2);

    $display("[TB] output stall with ignored input");
    applyStimulus(1, 48'h0, 10, 1'b1, lat, res);
    checkOutput("stallData", res, 32'hEFA72C4D);
    checkOutput("stallReadyAfter", 32'(inReady[1]), 32'd1);
    repeat (3) @(negedge clk);

    $display("[TB] clear during step 1");
    inValid[1] = 1'b1;
    in48[1]    = 48'h123456789ABC;
    @(negedge clk);
    inValid[1] = 1'b0;
    @(negedge clk);
    clearIn[1] = 1'b1;
    @(negedge clk);
    clearIn[1] = 1'b0;
    checkOutput("clrInReady", 32'(inReady[1]), 32'd1);
    checkOutput("clrBusy", 32'(busy[1]), 32'd0);
    checkOutput("clrOutValid", 32'(outValid[1]), 32'd0);
    repeat (6) @(negedge clk);
    applyStimulus(1, 48'h0, 0, 1'b0, lat, res);
    checkOutput("postClrData", res, 32'hEFA72C4D);
    checkOutput("postClrLat", 32'(lat), 32'd4);

    $display("[TB] clear beats input handshake");
    clearIn[0] = 1'b1;
    inValid[0] = 1'b1;
    in48[0]    = 48'hABCDEF012345;
    @(negedge clk);
    clearIn[0] = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("clrPrioBusy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] asynchronous reset in DONE");
    inValid[1] = 1'b1;
    in48[1]    = 48'hFFFFFFFFFFFF;
    @(negedge clk);
    inValid[1] = 1'b0;
    lat = 0;
    while (!outValid[1] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("preRstValid", 32'(outValid[1]), 32'd1);
    #2 nRst = 1'b0;
    #1;
    checkOutput("asyncOutValid", 32'(outValid[1]), 32'd0);
    checkOutput("asyncBusy", 32'(busy[1]), 32'd0);
    checkOutput("asyncOut32", out32[1], 32'd0);
    checkOutput("asyncInReady", 32'(inReady[1]), 32'd1);
    @(negedge clk);
    #2 nRst = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] random traffic");
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 200; n++) begin
        blk = {16'($urandom), $urandom};
        applyStimulus(i, blk, int'($urandom_range(0, 3)), 1'b0, lat, res);
        checkOutput($sformatf("rndData[%0d]", i), res, refModel(blk));
        checkOutput($sformatf("rndLat[%0d]", i), 32'(lat), 32'(STEPS_OF[i]));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
